// File: rtl/uart_pkg.sv
// Shared definitions for the UART link: FSM state encoding, parity types and
// prescale width, plus the prescale sanitising helper.
package uart_pkg;

  localparam int PRSC_W = 6;

  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } tx_state_e;

  // A latched prescale of zero would never produce a bit boundary; run it as one.
  function automatic logic [PRSC_W-1:0] eff_prescale(input logic [PRSC_W-1:0] p);
    return (p == '0) ? PRSC_W'(1) : p;
  endfunction

endpackage

// File: rtl/tx_bit_timer.sv
// Bit timer: edge_cnt runs 0..prescale-1 while enabled; bit_cnt steps on each wrap.
// clr restarts both counters so every FSM state begins on a fresh bit.
module tx_bit_timer
  import uart_pkg::*;
#(
  parameter int BIT_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              clr,
  input  logic [PRSC_W-1:0] prescale,
  output logic              edge_done,
  output logic [BIT_W-1:0]  bit_cnt
);

  logic [PRSC_W-1:0] edge_cnt;

  assign edge_done = en && (edge_cnt == prescale - PRSC_W'(1));

  // NOTE: sequential state uses non-blocking assignments so every flop updates
  // from pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      edge_cnt <= '0;
      bit_cnt  <= '0;
    end else if (en) begin
      if (edge_done) begin
        edge_cnt <= '0;
        bit_cnt  <= bit_cnt + BIT_W'(1);
      end else begin
        edge_cnt <= edge_cnt + PRSC_W'(1);
      end
    end
  end

endmodule

// File: rtl/uart_tx_frame.sv
// UART transmitter: serialises start, DATA_W data bits LSB first, optional parity
// and stop on TX_OUT, each bit held for the prescale latched at accept.
module uart_tx_frame
  import uart_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic [DATA_W-1:0] P_Data,
  input  logic              Data_Valid,
  input  logic              Par_En,
  input  logic              Par_Typ,
  input  logic [PRSC_W-1:0] Prescale,
  output logic              TX_OUT,
  output logic              Busy
);

  localparam int BIT_W = $clog2(DATA_W + 1);
  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_W - 1);

  tx_state_e         state, state_next;
  logic [DATA_W-1:0] shreg, shreg_next;
  logic              par_q;
  logic              par_en_q;
  logic [PRSC_W-1:0] prsc_q;
  logic              accept;
  logic              tx_next;
  logic              busy_next;
  logic              timer_en;
  logic              timer_clr;
  logic              edge_done;
  logic [BIT_W-1:0]  bit_cnt;

  tx_bit_timer #(.BIT_W(BIT_W)) u_timer (
    .clk       (Clk),
    .rst       (Rst),
    .en        (timer_en),
    .clr       (timer_clr),
    .prescale  (prsc_q),
    .edge_done (edge_done),
    .bit_cnt   (bit_cnt)
  );

  // NOTE: every signal driven here gets a default first, so no path leaves it
  // unassigned and no latch is inferred.
  always_comb begin
    state_next = state;
    shreg_next = shreg;
    accept     = 1'b0;
    unique case (state)
      IDLE: begin
        if (Data_Valid) begin
          accept     = 1'b1;
          state_next = START;
          shreg_next = P_Data;
        end
      end
      START:  if (edge_done) state_next = DATA;
      DATA: begin
        if (edge_done) begin
          shreg_next = shreg >> 1;
          if (bit_cnt == LAST_BIT) state_next = par_en_q ? PARITY : STOP;
        end
      end
      PARITY: if (edge_done) state_next = STOP;
      STOP:   if (edge_done) state_next = IDLE;
      default: state_next = IDLE;
    endcase

    // Outputs are decoded from the next state so they can be registered
    // without lagging the FSM by a cycle.
    tx_next = 1'b1;
    unique case (state_next)
      START:   tx_next = 1'b0;
      DATA:    tx_next = shreg_next[0];
      PARITY:  tx_next = par_q;
      default: tx_next = 1'b1;
    endcase
    busy_next = (state_next != IDLE);

    timer_en  = (state != IDLE);
    timer_clr = (state == IDLE) || (state_next != state);
  end

  always_ff @(posedge Clk) begin
    // NOTE: the small datapath flops are reset along with the FSM; this is not
    // a memory array, so the reset costs nothing worth avoiding.
    if (Rst) begin
      state    <= IDLE;
      shreg    <= '0;
      par_q    <= 1'b0;
      par_en_q <= 1'b0;
      prsc_q   <= PRSC_W'(1);
      TX_OUT   <= 1'b1;
      Busy     <= 1'b0;
    end else begin
      state  <= state_next;
      shreg  <= shreg_next;
      TX_OUT <= tx_next;
      Busy   <= busy_next;
      if (accept) begin
        par_en_q <= Par_En;
        par_q    <= (Par_Typ == PAR_ODD) ? ~^P_Data : ^P_Data;
        prsc_q   <= eff_prescale(Prescale);
      end
    end
  end

endmodule
